data_mem_wbuf: RTL and testbench
================================

// Module: data_mem_wbuf
// PURPOSE
//  Word-addressed data memory with a posted-write buffer, directly downstream of the core datapath.
//  Consumes ALUOut (address) and WriteData from the datapath and returns read_data combinationally for MemtoReg.
//  Stores are queued in a small FIFO and drained into a single-port RAM on cycles with no load.
//  Loads are forwarded from the youngest matching buffer entry.
// PARAMETERS
//  AW        8   RAM word-address width; RAM holds 2**AW 32-bit words
//  WB_DEPTH  4   write-buffer entries (power of 2, >=2)
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-low reset
//  mem_read    in   1   load this cycle; claims the RAM port and blocks the drain
//  mem_write   in   1   store request this cycle
//  addr        in   32  word address (datapath ALUOut); only addr[AW-1:0] is used
//  write_data  in   32  store data (datapath WriteData)
//  read_data   out  32  load data, combinational from addr
//  stall       out  1   store not accepted; the core must hold PC and the instruction
//  wb_count    out  $clog2(WB_DEPTH)+1  occupied buffer entries (registered)
//  wb_empty    out  1   wb_count==0
// BEHAVIOUR
//  - Addressing: word-addressed, no byte offset or shift; addr[31:AW] ignored (aliases).
//  - Reset (reset==0, async): buffer emptied, head/tail/wb_count=0, wb_empty=1, stall=0.
//    Pending stores are discarded. RAM contents are NOT cleared.
//    Reset mid-drain: the in-flight entry is dropped.
//  - FIFO state: head ptr, tail ptr, wb_count. Ptrs are log2(WB_DEPTH) bits and wrap modulo WB_DEPTH.
//  - Full when wb_count==WB_DEPTH.
//    stall = mem_write & full (combinational from registered count).
//    stall is asserted even if a drain frees an entry on the same edge; the retry is accepted next cycle.
//  - Enqueue at posedge when mem_write & !full: entry[tail] <= {addr[AW-1:0], write_data}; tail++.
//  - Drain at posedge when wb_count>0 & !mem_read: RAM[entry[head].a] <= entry[head].d; head++.
//    Maximum one drain per cycle.
//  - Enqueue and drain on the same edge: wb_count unchanged. Otherwise wb_count changes by +/-1.
//  - read_data is driven every cycle, independent of mem_read:
//    = data of the YOUNGEST valid entry with a == addr[AW-1:0] (priority from tail-1 back to head),
//      else RAM[addr[AW-1:0]].
//    The store being enqueued in the same cycle is NOT visible; loads see state before this cycle's store.
//  - A store to an address already in the buffer allocates a new entry (no merging).
//    Drain order is strict FIFO, so RAM ends with the last value written.
//  - Latency:
//    - load: 0 cycles (combinational);
//    - store visible to loads: next cycle (via forwarding);
//    - store in RAM: >=1 cycle after enqueue, delayed by queued entries and by load cycles.
//  - Back-to-back loads starve the drain indefinitely; that is by design. The core sees stall only on stores.
//  - No X on read_data after reset for any address previously written since power-up.
// TESTING
//  1 Reset: drive reset=0 mid-run -> wb_count=0, wb_empty=1, stall=0 immediately (asynchronous).
//  2 Store addr=5 data=0xDEADBEEF, then load addr=5 -> read_data=0xDEADBEEF, wb_count=1.
//    Then one idle cycle -> wb_count=0, RAM[5]=0xDEADBEEF, load addr=5 still returns 0xDEADBEEF.
//  3 With mem_read=1 held: store addr=7 0x11, then addr=7 0x22 -> load addr=7 returns 0x22, wb_count=2.
//    Release mem_read -> after 2 cycles RAM[7]=0x22.
//  4 Hold mem_read=1 and issue 4 stores -> wb_count=4.
//    5th store -> stall=1, entry not enqueued.
//    Drop mem_read for 1 cycle -> wb_count=3; the retried store is then accepted, stall=0.
//  5 Pre-load RAM[3]=0xA5; with mem_read=1, store addr=3 0x5A, then assert reset=0 ->
//    buffer empty, load addr=3 returns 0xA5 (pending store discarded).
//  6 Alias/wrap: store addr=0x105 0x77, drain -> RAM[0x05]=0x77 (AW=8).
//    Run 9 store/drain pairs -> pointers wrap, ordering preserved.

Source files
------------

// File: rtl/data_mem_wbuf_if.sv
// Load/store port between the core datapath and the data memory with posted-write buffer.
// The core side drives the request and the memory side returns load data and buffer status.
interface data_mem_wbuf_if #(
  parameter int WB_DEPTH = 4
);
  localparam int CW = $clog2(WB_DEPTH) + 1;

  logic          mem_read;
  logic          mem_write;
  logic [31:0]   addr;
  logic [31:0]   write_data;
  logic [31:0]   read_data;
  logic          stall;
  logic [CW-1:0] wb_count;
  logic          wb_empty;

  modport master (
    output mem_read, mem_write, addr, write_data,
    input  read_data, stall, wb_count, wb_empty
  );

  modport slave (
    input  mem_read, mem_write, addr, write_data,
    output read_data, stall, wb_count, wb_empty
  );
endinterface

// File: rtl/data_mem_wbuf.sv
// Word-addressed data RAM with a posted-write FIFO. Stores drain on cycles without a load.
// Loads forward from the youngest matching buffer entry.
module data_mem_wbuf #(
  parameter int AW       = 8,
  parameter int WB_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  data_mem_wbuf_if.slave   bus
);
  localparam int PW        = $clog2(WB_DEPTH);
  localparam int CW        = PW + 1;
  localparam int RAM_WORDS = 1 << AW;

  logic [31:0]   ram_r      [RAM_WORDS];
  logic [AW-1:0] ent_addr_r [WB_DEPTH];
  logic [31:0]   ent_data_r [WB_DEPTH];

  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] wb_count_r;
  logic          wb_empty_r;

  logic          full_s;
  logic          enq_s;
  logic          drain_s;
  logic [CW-1:0] count_nxt_s;
  logic [AW-1:0] word_s;
  logic [PW-1:0] idx_s;
  logic          fwd_hit_s;
  logic [31:0]   fwd_data_s;
  logic          unused_addr_s;

  // Upper address bits alias onto the RAM.
  assign word_s        = bus.addr[AW-1:0];
  assign unused_addr_s = &bus.addr[31:AW];

  // Enqueue/drain decisions and the next occupancy.
  always_comb begin
    full_s      = (wb_count_r == CW'(WB_DEPTH));
    enq_s       = bus.mem_write & ~full_s;
    drain_s     = (wb_count_r != {CW{1'b0}}) & ~bus.mem_read;
    count_nxt_s = wb_count_r;
    case ({enq_s, drain_s})
      2'b10:   count_nxt_s = wb_count_r + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_nxt_s = wb_count_r - {{(CW-1){1'b0}}, 1'b1};
      default: count_nxt_s = wb_count_r;
    endcase
  end

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_data_s = 32'h0000_0000;
    idx_s      = head_r;
    for (int i = 0; i < WB_DEPTH; i++) begin
      idx_s = head_r + PW'(i);
      if ((CW'(i) < wb_count_r) && (ent_addr_r[idx_s] == word_s)) begin
        fwd_hit_s  = 1'b1;
        fwd_data_s = ent_data_r[idx_s];
      end else begin
        fwd_hit_s  = fwd_hit_s;
        fwd_data_s = fwd_data_s;
      end
    end
  end

  assign bus.read_data = fwd_hit_s ? fwd_data_s : ram_r[word_s];
  assign bus.stall     = bus.mem_write & full_s;
  assign bus.wb_count  = wb_count_r;
  assign bus.wb_empty  = wb_empty_r;

  // FIFO pointers and occupancy; reset discards every pending store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r     <= {PW{1'b0}};
      tail_r     <= {PW{1'b0}};
      wb_count_r <= {CW{1'b0}};
      wb_empty_r <= 1'b1;
    end else begin
      if (enq_s) begin
        tail_r <= tail_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (drain_s) begin
        head_r <= head_r + {{(PW-1){1'b0}}, 1'b1};
      end
      wb_count_r <= count_nxt_s;
      wb_empty_r <= (count_nxt_s == {CW{1'b0}});
    end
  end

  // Buffer payload; only slots below wb_count are ever consulted.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      ent_addr_r[tail_r] <= word_s;
      ent_data_r[tail_r] <= bus.write_data;
    end
  end

  // Single-port RAM write from the buffer head; contents survive reset.
  always_ff @(posedge clk) begin
    if (drain_s) begin
      ram_r[ent_addr_r[head_r]] <= ent_data_r[head_r];
    end
  end
endmodule

// File: tb/tb_data_mem_wbuf.sv
// Directed bench for data_mem_wbuf: a queue/array model of the write buffer and RAM is checked
// every cycle, plus literal expectations from the documented scenarios.
module tb_data_mem_wbuf;
  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_wbuf_if #(.WB_DEPTH(DEPTH)) bus();

  data_mem_wbuf #(.AW(8), .WB_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  ent_t        q[$];
  logic [31:0] mram [int];
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_read(input logic [7:0] a, output logic [31:0] d);
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].a == a) begin
        d = q[i].d;
        return 1'b1;
      end
    end
    if (mram.exists(int'(a))) begin
      d = mram[int'(a)];
      return 1'b1;
    end
    d = 32'h0;
    return 1'b0;
  endfunction

  // Model: drain the oldest entry when not loading, then append the accepted store.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
    end else begin
      bit full;
      bit enq;
      bit drn;
      full = (q.size() == DEPTH);
      enq  = bus.mem_write && !full;
      drn  = (q.size() > 0) && !bus.mem_read;
      if (drn) begin
        mram[int'(q[0].a)] = q[0].d;
        void'(q.pop_front());
      end
      if (enq) begin
        q.push_back('{bus.addr[7:0], bus.write_data});
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [31:0] d;
      bit          known;
      known = model_read(bus.addr[7:0], d);
      check("stall", {31'b0, bus.stall}, {31'b0, (bus.mem_write && q.size() == DEPTH)});
      check("wb_count", 32'(bus.wb_count), 32'(q.size()));
      check("wb_empty", {31'b0, bus.wb_empty}, {31'b0, (q.size() == 0)});
      if (known) begin
        check("read_data", bus.read_data, d);
      end
    end
  end

  task automatic set_in(input bit mr, input bit mw, input logic [31:0] a, input logic [31:0] d);
    bus.mem_read   = mr;
    bus.mem_write  = mw;
    bus.addr       = a;
    bus.write_data = d;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    #1;
    check("rst_count", 32'(bus.wb_count), 32'd0);
    check("rst_empty", {31'b0, bus.wb_empty}, 32'd1);
    check("rst_stall", {31'b0, bus.stall}, 32'd0);
    step();
    step();
    reset = 1'b1;

    // Store then load forwards; one idle cycle drains to RAM.
    set_in(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    step();
    set_in(1'b1, 1'b0, 32'd5, 32'h0);
    #1;
    check("t2_fwd", bus.read_data, 32'hDEAD_BEEF);
    check("t2_count1", 32'(bus.wb_count), 32'd1);
    step();
    set_in(1'b0, 1'b0, 32'd5, 32'h0);
    step();
    #1;
    check("t2_count0", 32'(bus.wb_count), 32'd0);
    check("t2_empty", {31'b0, bus.wb_empty}, 32'd1);
    check("t2_ram", bus.read_data, 32'hDEAD_BEEF);

    // Two stores to one address under held load: youngest wins, RAM ends with the last.
    set_in(1'b1, 1'b1, 32'd7, 32'h11);
    step();
    set_in(1'b1, 1'b1, 32'd7, 32'h22);
    step();
    set_in(1'b1, 1'b0, 32'd7, 32'h0);
    #1;
    check("t3_youngest", bus.read_data, 32'h22);
    check("t3_count2", 32'(bus.wb_count), 32'd2);
    step();
    set_in(1'b0, 1'b0, 32'd7, 32'h0);
    step();
    step();
    #1;
    check("t3_count0", 32'(bus.wb_count), 32'd0);
    check("t3_ram", bus.read_data, 32'h22);

    // Fill under held load, then stall and retry.
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 1'b1, 32'h10 + 32'(i), 32'h1000 + 32'(i));
      step();
    end
    set_in(1'b1, 1'b1, 32'h20, 32'h99);
    #1;
    check("t4_count4", 32'(bus.wb_count), 32'd4);
    check("t4_stall", {31'b0, bus.stall}, 32'd1);
    step();
    set_in(1'b0, 1'b1, 32'h20, 32'h99);
    #1;
    check("t4_still_full", 32'(bus.wb_count), 32'd4);
    check("t4_stall_drain", {31'b0, bus.stall}, 32'd1);
    step();
    set_in(1'b1, 1'b1, 32'h20, 32'h99);
    #1;
    check("t4_count3", 32'(bus.wb_count), 32'd3);
    check("t4_retry", {31'b0, bus.stall}, 32'd0);
    step();
    set_in(1'b0, 1'b0, 32'h20, 32'h0);
    #1;
    check("t4_refull", 32'(bus.wb_count), 32'd4);
    check("t4_fwd", bus.read_data, 32'h99);
    repeat (DEPTH) step();
    set_in(1'b0, 1'b0, 32'h12, 32'h0);
    #1;
    check("t4_drained", 32'(bus.wb_count), 32'd0);
    check("t4_ram", bus.read_data, 32'h1002);

    // Reset discards a pending store; RAM keeps its old value.
    set_in(1'b0, 1'b1, 32'd3, 32'hA5);
    step();
    set_in(1'b0, 1'b0, 32'd3, 32'h0);
    step();
    set_in(1'b1, 1'b1, 32'd3, 32'h5A);
    step();
    set_in(1'b1, 1'b1, 32'd3, 32'h0);
    #1;
    check("t5_fwd", bus.read_data, 32'h5A);
    check("t5_count1", 32'(bus.wb_count), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("t5_rst_count", 32'(bus.wb_count), 32'd0);
    check("t5_rst_empty", {31'b0, bus.wb_empty}, 32'd1);
    check("t5_rst_stall", {31'b0, bus.stall}, 32'd0);
    check("t5_ram", bus.read_data, 32'hA5);
    step();
    reset = 1'b1;
    set_in(1'b0, 1'b0, 32'd3, 32'h0);
    step();

    // Aliased address lands at the low word.
    set_in(1'b0, 1'b1, 32'h105, 32'h77);
    step();
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    set_in(1'b0, 1'b0, 32'h05, 32'h0);
    #1;
    check("t6_alias", bus.read_data, 32'h77);
    check("t6_empty", {31'b0, bus.wb_empty}, 32'd1);

    // Nine store/drain pairs wrap the pointers.
    for (int i = 0; i < 9; i++) begin
      set_in(1'b0, 1'b1, 32'h50, 32'h100 + 32'(i));
      step();
      set_in(1'b0, 1'b0, 32'h50, 32'h0);
      step();
    end
    #1;
    check("t6_wrap", bus.read_data, 32'h108);

    // Back-to-back overlapping store/drain after the wrap.
    for (int i = 0; i < 6; i++) begin
      set_in(1'b0, 1'b1, 32'h60 + 32'(i % 2), 32'h200 + 32'(i));
      step();
    end
    set_in(1'b0, 1'b0, 32'h61, 32'h0);
    step();
    #1;
    check("t6_last", bus.read_data, 32'h205);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
